// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic inter-stage pipeline buffer with a valid/ready
// handshake. It holds up to DEPTH entries in a circular buffer and shows a
// bubble (NOP) value whenever it is empty. It also keeps a saturating count of
// the valid entries that flushes discard.
module pipe_stage_buf #(
  parameter int                 DATA_W     = 32,
  parameter int                 DEPTH      = 2,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [2:0]        count,
  output logic [7:0]        flush_drops
);

  // Storage is sized for the largest legal DEPTH. A 2-bit pointer can then
  // index it directly, and entries at or above DEPTH are never addressed.
  localparam int             SLOTS    = 4;
  localparam logic [2:0]     DEPTH_C  = 3'(DEPTH);
  localparam logic [1:0]     LAST_PTR = 2'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [SLOTS];
  logic [DATA_W-1:0] mem_d [SLOTS];
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [2:0]        count_q, count_d;
  logic [7:0]        flush_drops_q, flush_drops_d;

  logic              in_ready_s;
  logic              out_valid_s;
  logic              push_s;
  logic              pop_s;
  logic [8:0]        drop_sum_s;

  // Advance a pointer by one, wrapping modulo DEPTH.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    if (p == LAST_PTR) begin
      return 2'd0;
    end else begin
      return p + 2'd1;
    end
  endfunction

  // Handshake status derived only from registered occupancy. out_ready has no
  // path to in_ready.
  always_comb begin
    in_ready_s  = (count_q < DEPTH_C);
    out_valid_s = (count_q != 3'd0);
    push_s      = in_valid && in_ready_s;
    pop_s       = out_valid_s && out_ready;
    drop_sum_s  = {1'b0, flush_drops_q} + {6'd0, count_q};
  end

  // Next-state computation. Flush outranks push/pop; reset is applied in the
  // register process.
  always_comb begin
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    flush_drops_d = flush_drops_q;
    if (flush) begin
      rd_ptr_d      = 2'd0;
      wr_ptr_d      = 2'd0;
      count_d       = 3'd0;
      flush_drops_d = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= 2'd0;
      wr_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
      flush_drops_q <= 8'd0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      flush_drops_q <= flush_drops_d;
    end
  end

  // Payload storage. It is not reset because out_data is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Outputs come straight from registers, or through the bubble mux.
  always_comb begin
    in_ready    = in_ready_s;
    out_valid   = out_valid_s;
    count       = count_q;
    flush_drops = flush_drops_q;
    if (out_valid_s) begin
      out_data = mem_q[rd_ptr_q];
    end else begin
      out_data = BUBBLE_VAL;
    end
  end

endmodule
